// File: rtl/obj_pos_motion.sv
// Object horizontal position register with resp strobe load and timed HMOVE motion.
// Define OBJ_POS_RESP_OFFSET_EN to add RESP_OFFSET to visible-line resp loads.
module obj_pos_motion #(
  parameter int POS_MAX        = 160,
  parameter int RESP_BLANK_POS = 3,
  parameter int RESP_OFFSET    = 5,
  parameter int STEP_CLKS      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pixel_num,
  input  logic       resp,
  input  logic       hm_we,
  input  logic [3:0] hm_data,
  input  logic       hmclr,
  input  logic       hmove,
  output logic [7:0] obj_pos,
  output logic       busy,
  output logic [3:0] hm_reg
);

  localparam int                DIV_W     = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(STEP_CLKS - 1);
  localparam logic [7:0]        POS_LAST  = 8'(POS_MAX - 1);
  localparam logic [8:0]        POS_MAX_9 = 9'(POS_MAX);

  typedef enum logic {IDLE = 1'b0, MOVE = 1'b1} state_e;

  state_e           state_q;
  logic [DIV_W-1:0] div_q;
  logic [3:0]       remain_q;
  logic             dir_left_q;
  logic [7:0]       pos_q;
  logic [3:0]       hm_q;

  logic [7:0]       resp_pos_d;
  logic [7:0]       step_pos_d;
  logic [3:0]       mag_d;

  // Position loaded by a resp strobe
`ifdef OBJ_POS_RESP_OFFSET_EN
  logic [8:0] resp_sum_d;
  always_comb begin
    resp_sum_d = {1'b0, pixel_num} + 9'(RESP_OFFSET);
    resp_pos_d = 8'(RESP_BLANK_POS);
    if ({1'b0, pixel_num} < POS_MAX_9) begin
      if (resp_sum_d >= POS_MAX_9) begin
        resp_pos_d = 8'(resp_sum_d - POS_MAX_9);
      end else begin
        resp_pos_d = resp_sum_d[7:0];
      end
    end else begin
      resp_pos_d = 8'(RESP_BLANK_POS);
    end
  end
`else
  always_comb begin
    resp_pos_d = 8'(RESP_BLANK_POS);
    if ({1'b0, pixel_num} < POS_MAX_9) begin
      resp_pos_d = pixel_num;
    end else begin
      resp_pos_d = 8'(RESP_BLANK_POS);
    end
  end
`endif

  // One-pixel step with wrap; positive motion moves left (decrement)
  always_comb begin
    step_pos_d = pos_q;
    if (dir_left_q) begin
      if (pos_q == 8'd0) begin
        step_pos_d = POS_LAST;
      end else begin
        step_pos_d = pos_q - 8'd1;
      end
    end else begin
      if (pos_q == POS_LAST) begin
        step_pos_d = 8'd0;
      end else begin
        step_pos_d = pos_q + 8'd1;
      end
    end
  end

  // Magnitude of the signed motion register; -8 maps to 4'd8
  always_comb begin
    mag_d = hm_q;
    if (hm_q[3]) begin
      mag_d = ~hm_q + 4'd1;
    end else begin
      mag_d = hm_q;
    end
  end

  // Motion register, position and IDLE/MOVE sequencer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      remain_q   <= 4'd0;
      dir_left_q <= 1'b0;
      pos_q      <= 8'd0;
      hm_q       <= 4'd0;
    end else begin
      if (hmclr) begin
        hm_q <= 4'd0;
      end else if (hm_we) begin
        hm_q <= hm_data;
      end

      case (state_q)
        IDLE: begin
          if (resp) begin
            pos_q <= resp_pos_d;
          end
          if (hmove && (hm_q != 4'd0)) begin
            state_q    <= MOVE;
            div_q      <= '0;
            remain_q   <= mag_d;
            dir_left_q <= ~hm_q[3];
          end
        end
        MOVE: begin
          if (div_q == DIV_LAST) begin
            // The step is consumed even if resp overrides the position
            div_q    <= '0;
            remain_q <= remain_q - 4'd1;
            pos_q    <= resp ? resp_pos_d : step_pos_d;
            if (remain_q == 4'd1) begin
              state_q <= IDLE;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
            if (resp) begin
              pos_q <= resp_pos_d;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign obj_pos = pos_q;
  assign busy    = (state_q == MOVE);
  assign hm_reg  = hm_q;

endmodule

// File: tb/tb_obj_pos_motion.sv
// Directed self-checking bench for obj_pos_motion (default parameters).
module tb_obj_pos_motion;

`ifdef OBJ_POS_RESP_OFFSET_EN
  localparam int OFF = 5;
`else
  localparam int OFF = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pixel_num;
  logic       resp;
  logic       hm_we;
  logic [3:0] hm_data;
  logic       hmclr;
  logic       hmove;
  logic [7:0] obj_pos;
  logic       busy;
  logic [3:0] hm_reg;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  obj_pos_motion dut (
    .clk       (clk),
    .reset     (reset),
    .pixel_num (pixel_num),
    .resp      (resp),
    .hm_we     (hm_we),
    .hm_data   (hm_data),
    .hmclr     (hmclr),
    .hmove     (hmove),
    .obj_pos   (obj_pos),
    .busy      (busy),
    .hm_reg    (hm_reg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got == exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pos(input int pix);
    pixel_num = 8'(pix);
    resp      = 1'b1;
    tick();
    resp      = 1'b0;
  endtask

  task automatic write_hm(input logic [3:0] v);
    hm_data = v;
    hm_we   = 1'b1;
    tick();
    hm_we   = 1'b0;
  endtask

  task automatic start_move();
    hmove = 1'b1;
    tick();
    hmove = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pixel_num = 8'd0; resp = 1'b0; hm_we = 1'b0;
    hm_data = 4'd0; hmclr = 1'b0; hmove = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_pos", int'(obj_pos), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_hm", int'(hm_reg), 0);

    load_pos(40);
    chk("resp40", int'(obj_pos), 40 + OFF);
    load_pos(200);
    chk("resp_blank", int'(obj_pos), 3);

    // +3 motion from 10: steps left at cycles 4, 8, 12
    load_pos(10 - OFF);
    chk("resp10", int'(obj_pos), 10);
    write_hm(4'd3);
    chk("hm_wr", int'(hm_reg), 3);
    start_move();
    chk("mv_busy0", int'(busy), 1);
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk($sformatf("mv_busy%0d", c), int'(busy), (c < 12) ? 1 : 0);
      if (c % 4 == 0) chk($sformatf("mv_pos%0d", c), int'(obj_pos), 10 - c / 4);
    end

    // -8 motion from 158 wraps through 159, 0 to 6
    load_pos(158 - OFF);
    chk("resp158", int'(obj_pos), 158);
    write_hm(4'b1000);
    start_move();
    for (int c = 1; c <= 32; c++) begin
      tick();
      if (c == 4)  chk("wrap_159", int'(obj_pos), 159);
      if (c == 8)  chk("wrap_0", int'(obj_pos), 0);
      if (c == 31) chk("wrap_busy31", int'(busy), 1);
    end
    chk("wrap_end", int'(obj_pos), 6);
    chk("wrap_idle", int'(busy), 0);

    // hmclr beats hm_we; zero motion does nothing
    hm_data = 4'd5; hm_we = 1'b1; hmclr = 1'b1;
    tick();
    hm_we = 1'b0; hmclr = 1'b0;
    chk("clr_wins", int'(hm_reg), 0);
    start_move();
    chk("zero_busy", int'(busy), 0);
    tick();
    chk("zero_busy2", int'(busy), 0);
    chk("zero_pos", int'(obj_pos), 6);

    // +3 from 6; resp on step cycle 4, hmove ignored, hm write mid-move
    write_hm(4'd3);
    start_move();
    for (int c = 1; c <= 12; c++) begin
      if (c == 4) begin pixel_num = 8'(80 - OFF); resp = 1'b1; end
      if (c == 5) hmove = 1'b1;
      if (c == 6) begin hm_data = 4'hF; hm_we = 1'b1; end
      tick();
      resp = 1'b0; hmove = 1'b0; hm_we = 1'b0;
      if (c == 3)  chk("mr_pre", int'(obj_pos), 6);
      if (c == 4)  chk("mr_load", int'(obj_pos), 80);
      if (c == 6)  chk("mr_hm", int'(hm_reg), 15);
      if (c == 8)  chk("mr_step8", int'(obj_pos), 79);
      if (c == 11) chk("mr_busy11", int'(busy), 1);
      if (c == 12) chk("mr_step12", int'(obj_pos), 78);
    end
    chk("mr_idle", int'(busy), 0);

    // -1 move right, then reset mid-sequence
    start_move();
    tick(); tick();
    chk("rm_busy", int'(busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_pos", int'(obj_pos), 0);
    chk("rm_busy0", int'(busy), 0);
    chk("rm_hm", int'(hm_reg), 0);
    tick(); tick(); tick(); tick();
    chk("rm_hold", int'(obj_pos), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
